pcpu_fetch: RTL

Instruction-fetch stage of the pipelined RV32I core. It holds the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register that feeds the decoder/control unit. It applies the next-PC operation resolved in EX: sequential, branch, JAL or JALR. It also handles stalls from the hazard unit and flushes on a taken redirect.

---
 rtl/pcpu_fetch.sv | 90 +++++++++
 1 files changed

// File: rtl/pcpu_fetch.sv
// Instruction-fetch stage: PC register, next-PC redirect from EX, and the IF/ID pipeline register.
// Redirects squash IF/ID and override stalls; misalign and flush_cnt are sticky diagnostics.
module pcpu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [2:0]  npc_op,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_alu,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_inst,
   output logic        if_id_valid,
   output logic        misalign,
   output logic [15:0] flush_cnt
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_inst_q, if_id_inst_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic        misalign_q, misalign_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;
   logic        redirect;
   logic [31:0] target_raw;

   always_comb begin
      redirect      = |npc_op;
      // JALR wins over JUMP/BRANCH; any set bit selects its source
      if (npc_op[2]) begin
         target_raw = ex_alu & ~32'h1;
      end else begin
         target_raw = ex_pc + ex_imm;
      end

      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_inst_d  = if_id_inst_q;
      if_id_valid_d = if_id_valid_q;
      misalign_d    = misalign_q;
      flush_cnt_d   = flush_cnt_q;

      if (redirect) begin
         pc_d          = {target_raw[31:2], 2'b00};
         if_id_pc_d    = 32'h0;
         if_id_inst_d  = NOP_INST;
         if_id_valid_d = 1'b0;
         misalign_d    = misalign_q | (|target_raw[1:0]);
         if (flush_cnt_q != 16'hFFFF) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
         end
      end else if (!stall) begin
         pc_d          = pc_q + 32'd4;
         if_id_pc_d    = pc_q;
         if_id_inst_d  = imem_rdata;
         if_id_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         if_id_pc_q    <= 32'h0;
         if_id_inst_q  <= NOP_INST;
         if_id_valid_q <= 1'b0;
         misalign_q    <= 1'b0;
         flush_cnt_q   <= 16'h0;
      end else begin
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_inst_q  <= if_id_inst_d;
         if_id_valid_q <= if_id_valid_d;
         misalign_q    <= misalign_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   assign imem_addr   = pc_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_inst  = if_id_inst_q;
   assign if_id_valid = if_id_valid_q;
   assign misalign    = misalign_q;
   assign flush_cnt   = flush_cnt_q;

endmodule
